data_bus_controller: RTL and testbench

- Shared 32-bit data-bus arbiter/router for the data & control router; connects the FFT, FIR and IIR processing units.
- Each cycle it selects at most one source unit requesting to put data, drives that word onto the internal data bus, and delivers it to every other unit requesting to get data that has buffer room.
- All outputs are registered, with single-cycle latency.

---
 rtl/data_bus_controller_pkg.sv | 19 +
 rtl/data_bus_controller_rr_arbiter3.sv | 45 ++++
 rtl/data_bus_controller.sv | 111 +++++++++++
 tb/tb_data_bus_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_controller_pkg.sv
// Shared definitions for the data bus controller: bus width, unit indices
// and the unit-select type used by the arbiter and the data router.
package data_bus_controller_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_UNITS = 3;

  typedef logic [1:0] unit_sel_t;

  localparam unit_sel_t UNIT_FFT = 2'd0;
  localparam unit_sel_t UNIT_FIR = 2'd1;
  localparam unit_sel_t UNIT_IIR = 2'd2;

  // Round-robin successor: FFT -> FIR -> IIR -> FFT.
  function automatic unit_sel_t next_unit(input unit_sel_t u);
    return (u == UNIT_IIR) ? UNIT_FFT : unit_sel_t'(u + 2'd1);
  endfunction

endpackage

// File: rtl/data_bus_controller_rr_arbiter3.sv
// Three-requester round-robin arbiter. The search starts at the pointer;
// the pointer moves past the winner only when the caller commits the grant.
module rr_arbiter3
  import data_bus_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       update,
  output logic [2:0] grant,
  output unit_sel_t  grant_idx,
  output logic       grant_valid
);

  unit_sel_t ptr;
  unit_sel_t cand;

  // Pick the first requester at or after the pointer in circular order.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cand        = ptr;
    grant_idx   = ptr;
    grant_valid = 1'b0;
    // Scan farthest-first so the nearest requester overwrites and wins.
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      cand = unit_sel_t'((int'(ptr) + k) % NUM_UNITS);
      if (req[cand]) begin
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
    grant = grant_valid ? (3'b001 << grant_idx) : 3'b000;
  end

  // Advance the pointer past a committed winner; hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= UNIT_FFT;
    end else if (update && grant_valid) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      ptr <= next_unit(grant_idx);
    end
  end

endmodule

// File: rtl/data_bus_controller.sv
// Shared data bus router between the FFT, FIR and IIR units. One source is
// chosen round-robin each cycle and its word is broadcast to every other unit
// that wants data and has room. All outputs are registered.
module data_bus_controller
  import data_bus_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fft_data_in,
  input  logic [DATA_W-1:0] fir_data_in,
  input  logic [DATA_W-1:0] iir_data_in,
  input  logic              fft_put_req,
  input  logic              fir_put_req,
  input  logic              iir_put_req,
  input  logic              fft_get_req,
  input  logic              fir_get_req,
  input  logic              iir_get_req,
  input  logic              fft_empty,
  input  logic              fir_empty,
  input  logic              iir_empty,
  input  logic              fft_full,
  input  logic              fir_full,
  input  logic              iir_full,
  output logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] fft_data_out,
  output logic [DATA_W-1:0] fir_data_out,
  output logic [DATA_W-1:0] iir_data_out,
  output logic              fft_put_ack,
  output logic              fir_put_ack,
  output logic              iir_put_ack,
  output logic              fft_get_ack,
  output logic              fir_get_ack,
  output logic              iir_get_ack
);

  logic [2:0]              put_ok;
  logic [2:0]              get_ok;
  logic [2:0]              grant;
  logic [2:0]              dest;
  unit_sel_t               grant_idx;
  logic                    grant_valid;
  logic                    xfer;
  logic [DATA_W-1:0]       win_word;

  logic [DATA_W-1:0]       bus_q;
  logic [2:0][DATA_W-1:0]  dout_q;
  logic [2:0]              put_ack_q;
  logic [2:0]              get_ack_q;

  // A source needs something to send; a destination needs room.
  assign put_ok = {iir_put_req & ~iir_empty, fir_put_req & ~fir_empty, fft_put_req & ~fft_empty};
  assign get_ok = {iir_get_req & ~iir_full,  fir_get_req & ~fir_full,  fft_get_req & ~fft_full};

  rr_arbiter3 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (put_ok),
    .update      (xfer),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // A unit never receives its own word; without any receiver nothing moves.
  assign dest = get_ok & ~grant;
  assign xfer = grant_valid & (|dest);

  // Route the winning unit's word onto the bus.
  always_comb begin
    win_word = fft_data_in;
    case (grant_idx)
      UNIT_FIR: win_word = fir_data_in;
      UNIT_IIR: win_word = iir_data_in;
      default:  win_word = fft_data_in;
    endcase
  end

  // Register the transfer: acks pulse for one cycle, data holds between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are control-visible output registers, so every one is reset; a reset also drops any in-flight transfer.
      bus_q     <= '0;
      dout_q    <= '0;
      put_ack_q <= '0;
      get_ack_q <= '0;
    end else begin
      put_ack_q <= xfer ? grant : 3'b000;
      get_ack_q <= xfer ? dest  : 3'b000;
      if (xfer) begin
        bus_q <= win_word;
      end
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (xfer && dest[i]) begin
          dout_q[i] <= win_word;
        end
      end
    end
  end

  assign data_bus     = bus_q;
  assign fft_data_out = dout_q[UNIT_FFT];
  assign fir_data_out = dout_q[UNIT_FIR];
  assign iir_data_out = dout_q[UNIT_IIR];
  assign fft_put_ack  = put_ack_q[UNIT_FFT];
  assign fir_put_ack  = put_ack_q[UNIT_FIR];
  assign iir_put_ack  = put_ack_q[UNIT_IIR];
  assign fft_get_ack  = get_ack_q[UNIT_FFT];
  assign fir_get_ack  = get_ack_q[UNIT_FIR];
  assign iir_get_ack  = get_ack_q[UNIT_IIR];

endmodule

// File: tb/tb_data_bus_controller.sv
// Scoreboard bench for data_bus_controller: a driver applies stimulus on the
// falling edge and pushes the reference model's prediction; a monitor pops
// and compares just after each rising edge.
module tb_data_bus_controller;
  import data_bus_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  put_req, get_req, empty, full;
  logic [31:0] din [3];
  logic [31:0] data_bus;
  logic [31:0] dout [3];
  logic [2:0]  pack, gack;

  always #5 clk = ~clk;

  data_bus_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fft_data_in  (din[0]),
    .fir_data_in  (din[1]),
    .iir_data_in  (din[2]),
    .fft_put_req  (put_req[0]),
    .fir_put_req  (put_req[1]),
    .iir_put_req  (put_req[2]),
    .fft_get_req  (get_req[0]),
    .fir_get_req  (get_req[1]),
    .iir_get_req  (get_req[2]),
    .fft_empty    (empty[0]),
    .fir_empty    (empty[1]),
    .iir_empty    (empty[2]),
    .fft_full     (full[0]),
    .fir_full     (full[1]),
    .iir_full     (full[2]),
    .data_bus     (data_bus),
    .fft_data_out (dout[0]),
    .fir_data_out (dout[1]),
    .iir_data_out (dout[2]),
    .fft_put_ack  (pack[0]),
    .fir_put_ack  (pack[1]),
    .iir_put_ack  (pack[2]),
    .fft_get_ack  (gack[0]),
    .fir_get_ack  (gack[1]),
    .iir_get_ack  (gack[2])
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0]       bus;
    logic [2:0][31:0]  dout;
    logic [2:0]        pack;
    logic [2:0]        gack;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  bit               mon_en = 1'b0;

  // Reference model state: whose turn it is, and what each output last held.
  int               m_ptr = 0;
  logic [31:0]      m_bus = '0;
  logic [2:0][31:0] m_dout = '0;

  task automatic model_reset();
    m_ptr  = 0;
    m_bus  = '0;
    m_dout = '0;
  endtask

  // Predict the outputs after the next rising edge from the current inputs.
  task automatic model_push();
    exp_t e;
    int   src;
    bit   any;
    e   = '0;
    src = -1;
    any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int u;
      u = (m_ptr + k) % 3;
      if (src < 0 && put_req[u] && !empty[u]) src = u;
    end
    if (src >= 0) begin
      for (int u = 0; u < 3; u++) begin
        if (u != src && get_req[u] && !full[u]) begin
          e.gack[u] = 1'b1;
          any = 1'b1;
        end
      end
    end
    if (any) begin
      m_bus = din[src];
      for (int u = 0; u < 3; u++) if (e.gack[u]) m_dout[u] = din[src];
      e.pack[src] = 1'b1;
      m_ptr = (src + 1) % 3;
    end else begin
      e.gack = '0;
    end
    e.bus  = m_bus;
    e.dout = m_dout;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] p, input logic [2:0] g, input logic [2:0] e,
                       input logic [2:0] f, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2);
    @(negedge clk);
    put_req = p; get_req = g; empty = e; full = f;
    din[0] = d0; din[1] = d1; din[2] = d2;
    model_push();
  endtask

  // Wait until just after the edge that consumes the last drive.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic randomize_inputs();
    put_req = 3'($urandom);
    get_req = 3'($urandom);
    for (int i = 0; i < 3; i++) begin
      empty[i] = ($urandom_range(3) == 0);
      full[i]  = ($urandom_range(3) == 0);
      din[i]   = $urandom;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " data_bus"}, data_bus, 32'h0);
    check({tag, " fft_data_out"}, dout[0], 32'h0);
    check({tag, " fir_data_out"}, dout[1], 32'h0);
    check({tag, " iir_data_out"}, dout[2], 32'h0);
    check({tag, " put_acks"}, {29'h0, pack}, 32'h0);
    check({tag, " get_acks"}, {29'h0, gack}, 32'h0);
  endtask

  // Monitor: compare every registered output against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("sb data_bus", data_bus, mon_e.bus);
        check("sb fft_data_out", dout[0], mon_e.dout[0]);
        check("sb fir_data_out", dout[1], mon_e.dout[1]);
        check("sb iir_data_out", dout[2], mon_e.dout[2]);
        check("sb put_acks", {29'h0, pack}, {29'h0, mon_e.pack});
        check("sb get_acks", {29'h0, gack}, {29'h0, mon_e.gack});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held from time zero with random inputs: outputs must be zero.
    randomize_inputs();
    #2;
    check_all_zero("por");
    @(negedge clk);
    put_req = '0; get_req = '0; empty = '0; full = '0;
    din[0] = '0; din[1] = '0; din[2] = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    model_reset();

    // Idle after release: nothing moves.
    drive(3'b000, 3'b000, 3'b000, 3'b000, 32'h0, 32'h0, 32'h0);
    drive(3'b000, 3'b111, 3'b000, 3'b000, 32'h11, 32'h22, 32'h33);

    // Single transfer FFT -> FIR.
    drive(3'b001, 3'b010, 3'b000, 3'b000, 32'hDEADBEEF, 32'h0, 32'h0);
    settle();
    check("single data_bus", data_bus, 32'hDEADBEEF);
    check("single fir_data_out", dout[1], 32'hDEADBEEF);
    check("single fft_data_out", dout[0], 32'h0);
    check("single iir_data_out", dout[2], 32'h0);
    check("single put_acks", {29'h0, pack}, 32'h1);
    check("single get_acks", {29'h0, gack}, 32'h2);

    // IIR broadcasts; FIR is full so only FFT receives.
    drive(3'b100, 3'b011, 3'b000, 3'b010, 32'h0, 32'h0, 32'h12345678);
    settle();
    check("bcast fft_data_out", dout[0], 32'h12345678);
    check("bcast fir_data_out", dout[1], 32'hDEADBEEF);
    check("bcast put_acks", {29'h0, pack}, 32'h4);
    check("bcast get_acks", {29'h0, gack}, 32'h1);

    // All put and all get for three cycles: turns rotate FFT, FIR, IIR.
    for (int c = 0; c < 3; c++) begin
      logic [31:0] exp_gack;
      drive(3'b111, 3'b111, 3'b000, 3'b000, 32'h1, 32'h2, 32'h3);
      settle();
      exp_gack = 32'h7 & ~(32'h1 << c);
      check("rr data_bus", data_bus, 32'(c + 1));
      check("rr put_acks", {29'h0, pack}, 32'h1 << c);
      check("rr get_acks", {29'h0, gack}, exp_gack);
    end

    // Stall: FFT empty, then all destinations full; pointer must stay at FFT.
    drive(3'b001, 3'b010, 3'b001, 3'b000, 32'hAA, 32'h0, 32'h0);
    settle();
    check("stall_empty acks", {26'h0, pack, gack}, 32'h0);
    check("stall_empty data_bus", data_bus, 32'h3);
    drive(3'b011, 3'b111, 3'b000, 3'b111, 32'hBB, 32'hCC, 32'h0);
    settle();
    check("stall_full acks", {26'h0, pack, gack}, 32'h0);
    check("stall_full data_bus", data_bus, 32'h3);
    drive(3'b011, 3'b010, 3'b000, 3'b000, 32'hCAFE0001, 32'hCAFE0002, 32'h0);
    settle();
    check("stall_resume put_acks", {29'h0, pack}, 32'h1);
    check("stall_resume fir_data_out", dout[1], 32'hCAFE0001);

    // Self-loop: FIR alone puts and gets -> no transfer.
    drive(3'b010, 3'b010, 3'b000, 3'b000, 32'h0, 32'h5555, 32'h0);
    settle();
    check("selfloop acks", {26'h0, pack, gack}, 32'h0);
    check("selfloop data_bus", data_bus, 32'hCAFE0001);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      randomize_inputs();
      model_push();
    end

    // Mid-cycle reset with random inputs: outputs clear without a clock edge.
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    randomize_inputs();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    sb_q.delete();
    model_reset();
    put_req = '0; get_req = '0; empty = '0; full = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drive(3'b000, 3'b111, 3'b000, 3'b000, 32'h9, 32'h9, 32'h9);
    // Pointer restarts at FFT after reset.
    drive(3'b111, 3'b111, 3'b000, 3'b000, 32'hF0, 32'hF1, 32'hF2);
    settle();
    check("postrst put_acks", {29'h0, pack}, 32'h1);

    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      randomize_inputs();
      model_push();
    end

    settle();
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
